// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 hard-decision Viterbi decoder: path metrics, survivor writes, traceback.
// Optional best-state traceback start: define VITERBI_FRAME_CTRL_BEST_STATE_EN.
module viterbi_frame_ctrl #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned INIT_PM     = 64,
  parameter int unsigned NORM_THRESH = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   frame_len_i,
  input  logic              sym_valid_i,
  output logic              sym_ready_o,
  output logic [7:0]        pm_s0_o,
  output logic [7:0]        pm_s1_o,
  output logic [7:0]        pm_s2_o,
  output logic [7:0]        pm_s3_o,
  input  logic [7:0]        pm_s0_i,
  input  logic [7:0]        pm_s1_i,
  input  logic [7:0]        pm_s2_i,
  input  logic [7:0]        pm_s3_i,
  input  logic [3:0]        dec_bits_i,
  output logic              surv_we_o,
  output logic [ADDR_W-1:0] surv_addr_o,
  output logic [3:0]        surv_data_o,
  output logic              tb_start_o,
  output logic [ADDR_W-1:0] tb_last_addr_o,
  output logic [1:0]        tb_state_o,
  input  logic              tb_done_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {StIdle, StRun, StTbReq, StTbWait, StDone} state_e;

  state_e            state_q;
  logic [7:0]        pm_q [4];
  logic [7:0]        pm_in [4];
  logic [7:0]        pm_nxt [4];
  logic [7:0]        pm_min;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] tb_last_q;
  logic [1:0]        tb_state_q;
  logic [1:0]        best_state;
  logic              accept;
  logic              last_step;

  assign accept    = (state_q == StRun) && sym_valid_i;
  assign last_step = ({1'b0, cnt_q} == (len_q - (ADDR_W+1)'(1)));

  // Metrics only grow, so subtracting the common minimum keeps them inside 8 bits.
  always_comb begin
    pm_in[0] = pm_s0_i;
    pm_in[1] = pm_s1_i;
    pm_in[2] = pm_s2_i;
    pm_in[3] = pm_s3_i;
    pm_min   = pm_in[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_in[i] < pm_min) pm_min = pm_in[i];
    end
    for (int i = 0; i < 4; i++) begin
      pm_nxt[i] = (pm_min >= 8'(NORM_THRESH)) ? pm_in[i] - pm_min : pm_in[i];
    end
  end

`ifdef VITERBI_FRAME_CTRL_BEST_STATE_EN
  logic [7:0] best_pm;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_state = 2'd0;
    best_pm    = pm_nxt[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_nxt[i] < best_pm) begin
        best_pm    = pm_nxt[i];
        best_state = 2'(i);
      end
    end
  end
`else
  assign best_state = 2'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pm_q       <= '{default: '0};
      cnt_q      <= '0;
      len_q      <= '0;
      tb_last_q  <= '0;
      tb_state_q <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q <= frame_len_i;
            if (frame_len_i == '0) begin
              state_q <= StDone;
            end else begin
              pm_q    <= '{8'd0, 8'(INIT_PM), 8'(INIT_PM), 8'(INIT_PM)};
              cnt_q   <= '0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            pm_q  <= pm_nxt;
            cnt_q <= cnt_q + ADDR_W'(1);
            if (last_step) begin
              tb_last_q  <= cnt_q;
              tb_state_q <= best_state;
              state_q    <= StTbReq;
            end
          end
        end
        StTbReq:  state_q <= StTbWait;
        StTbWait: if (tb_done_i) state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign sym_ready_o    = (state_q == StRun);
  assign surv_we_o      = accept;
  assign surv_addr_o    = cnt_q;
  assign surv_data_o    = (state_q == StRun) ? dec_bits_i : 4'd0;
  assign tb_start_o     = (state_q == StTbReq);
  assign tb_last_addr_o = tb_last_q;
  assign tb_state_o     = tb_state_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign pm_s0_o        = pm_q[0];
  assign pm_s1_o        = pm_q[1];
  assign pm_s2_o        = pm_q[2];
  assign pm_s3_o        = pm_q[3];

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: vector table, directed corner cases, random frames.
module tb_viterbi_frame_ctrl;

  logic             clk = 1'b0;
  logic             rst, start, sym_valid, sym_ready, tb_done;
  logic [6:0]       flen;
  logic [3:0][7:0]  pin;
  logic [3:0][7:0]  pm_out;
  logic [3:0]       dec, surv_data;
  logic             surv_we, tb_start, busy, done;
  logic [5:0]       surv_addr, tb_last;
  logic [1:0]       tb_state;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr;

  // Reference model state
  bit              m_run;
  int              m_cnt, m_len, m_tbstate;
  logic [3:0][7:0] m_pm;

  typedef struct {
    logic [3:0][7:0] pin;
    logic [3:0][7:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  viterbi_frame_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .frame_len_i(flen),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready),
    .pm_s0_o(pm_out[0]), .pm_s1_o(pm_out[1]), .pm_s2_o(pm_out[2]), .pm_s3_o(pm_out[3]),
    .pm_s0_i(pin[0]), .pm_s1_i(pin[1]), .pm_s2_i(pin[2]), .pm_s3_i(pin[3]),
    .dec_bits_i(dec), .surv_we_o(surv_we), .surv_addr_o(surv_addr), .surv_data_o(surv_data),
    .tb_start_o(tb_start), .tb_last_addr_o(tb_last), .tb_state_o(tb_state),
    .tb_done_i(tb_done), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][7:0] ref_norm(input logic [3:0][7:0] a);
    int m = 256;
    logic [3:0][7:0] r;
    foreach (a[i]) if (int'(a[i]) < m) m = int'(a[i]);
    foreach (a[i]) r[i] = (m >= 128) ? 8'(int'(a[i]) - m) : a[i];
    return r;
  endfunction

  function automatic int ref_best(input logic [3:0][7:0] a);
`ifdef VITERBI_FRAME_CTRL_BEST_STATE_EN
    int b = 0;
    for (int i = 1; i < 4; i++) if (a[i] < a[b]) b = i;
    return b;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1;
    flen  = 7'(len);
    tick();
    start = 1'b0;
    if (len > 0) begin
      m_run = 1'b1;
      m_cnt = 0;
      m_len = len;
      m_pm  = {8'd64, 8'd64, 8'd64, 8'd0};
    end
  endtask

  // One controller cycle: drive, check the combinational write, clock, check metrics.
  task automatic step(input bit v, input logic [3:0] d, input logic [3:0][7:0] p);
    bit acc;
    sym_valid = v;
    dec       = d;
    pin       = p;
    #2;
    acc = v && m_run;
    chk("sym_ready", sym_ready, m_run);
    chk("surv_we", surv_we, acc);
    if (acc) begin
      n_wr++;
      chk("surv_addr", surv_addr, m_cnt);
      chk("surv_data", surv_data, d);
    end
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    if (acc) begin
      m_pm = ref_norm(p);
      if (m_cnt == m_len - 1) begin
        m_run     = 1'b0;
        m_tbstate = ref_best(m_pm);
      end
      m_cnt++;
    end
    chk("pm", pm_out, m_pm);
  endtask

  task automatic finish_frame(input int gap);
    chk("tb_start_hi", tb_start, 1);
    chk("tb_last", tb_last, m_len - 1);
    chk("tb_state", tb_state, m_tbstate);
    chk("busy_tbreq", busy, 1);
    tick();
    chk("tb_start_lo", tb_start, 0);
    repeat (gap) begin
      tick();
      chk("done_wait", done, 0);
    end
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    chk("done_hi", done, 1);
    chk("pm_held", pm_out, m_pm);
    tick();
    chk("done_lo", done, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v;
    int len, guard;
    logic [3:0][7:0] p;

    vecs[0] = '{pin: {8'd200, 8'd140, 8'd135, 8'd130}, exp: {8'd70, 8'd10, 8'd5, 8'd0}};
    vecs[1] = '{pin: {8'd140, 8'd131, 8'd130, 8'd127}, exp: {8'd140, 8'd131, 8'd130, 8'd127}};
    vecs[2] = '{pin: {8'd128, 8'd128, 8'd128, 8'd128}, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{pin: {8'd150, 8'd128, 8'd200, 8'd255}, exp: {8'd22, 8'd0, 8'd72, 8'd127}};
    vecs[4] = '{pin: {8'd255, 8'd255, 8'd255, 8'd0}, exp: {8'd255, 8'd255, 8'd255, 8'd0}};
    vecs[5] = '{pin: {8'd131, 8'd250, 8'd255, 8'd129}, exp: {8'd2, 8'd121, 8'd126, 8'd0}};

    rst = 1'b1; start = 1'b0; flen = '0; sym_valid = 1'b0; tb_done = 1'b0;
    dec = 4'hf; pin = '1;
    m_run = 1'b0; m_pm = '0; m_cnt = 0; m_len = 0; m_tbstate = 0; n_wr = 0;
    tick(); tick();
    rst = 1'b0;
    tb_done = 1'b1;  // stray traceback completion in IDLE must be ignored
    repeat (5) tick();
    tb_done = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", sym_ready, 0);
    chk("rst_we", surv_we, 0);
    chk("rst_pm", pm_out, 0);
    chk("rst_done", done, 0);
    chk("rst_tb_start", tb_start, 0);
    chk("rst_tb_last", tb_last, 0);
    chk("rst_tb_state", tb_state, 0);
    chk("rst_surv_data", surv_data, 0);

    // Basic 4-step frame ending on metrics 9,3,3,7
    start_frame(4);
    chk("init_pm", pm_out, {8'd64, 8'd64, 8'd64, 8'd0});
    chk("init_ready", sym_ready, 1);
    for (int k = 0; k < 4; k++) begin
      p = (k == 3) ? {8'd7, 8'd3, 8'd3, 8'd9} : {8'(40 + k), 8'(30 + k), 8'(20 + k), 8'(10 + k)};
      step(1'b1, 4'(1 << k), p);
    end
`ifdef VITERBI_FRAME_CTRL_BEST_STATE_EN
    chk("best_state_dir", tb_state, 1);
`else
    chk("best_state_dir", tb_state, 0);
`endif
    finish_frame(1);

    // Normalisation table, then two random steps to close the 8-step frame
    start_frame(8);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'(i), vecs[i].pin);
      chk("norm_vec", pm_out, vecs[i].exp);
    end
    step(1'b1, 4'($urandom), $urandom);
    step(1'b1, 4'($urandom), $urandom);
    finish_frame(0);

    // Zero-length frame
    start_frame(0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_we", surv_we, 0);
    chk("len0_tb_start", tb_start, 0);
    tick();
    chk("len0_done_lo", done, 0);
    chk("len0_busy_lo", busy, 0);
    chk("len0_tb_start_lo", tb_start, 0);
    chk("len0_pm_held", pm_out, m_pm);

    // Gaps: valid 1,0,0,1,1 on a 3-step frame
    n_wr = 0;
    start_frame(3);
    foreach (vecs[i]) if (i < 5) step(i == 0 || i >= 3, 4'(i + 1), {8'(i), 8'(2 * i), 8'(50), 8'(i + 9)});
    chk("gap_writes", n_wr, 3);
    finish_frame(2);

    // Mid-frame reset after the second write
    n_wr = 0;
    start_frame(3);
    for (int i = 0; i < 4; i++) step(i == 0 || i == 3, 4'hc, {8'd60, 8'd70, 8'd80, 8'd90});
    chk("mid_writes", n_wr, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_run = 1'b0;
    m_pm  = '0;
    chk("mid_busy", busy, 0);
    chk("mid_ready", sym_ready, 0);
    chk("mid_pm", pm_out, 0);
    chk("mid_tb_start", tb_start, 0);
    chk("mid_addr", surv_addr, 0);
    chk("mid_tb_last", tb_last, 0);
    tick();
    chk("mid_tb_start2", tb_start, 0);
    chk("mid_done", done, 0);

    // Random frames with stalls and ignored start_i pulses while busy
    for (int f = 0; f < 20; f++) begin
      len   = $urandom_range(1, 12);
      guard = 0;
      start_frame(len);
      while (m_run && guard < 300) begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
          flen  = 7'($urandom);
        end
        step(v, 4'($urandom), $urandom);
        start = 1'b0;
        guard++;
      end
      if (m_run) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_frame_timeout: frame %0d still running, expected end of frame", f);
      end
      finish_frame($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
